// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient path: default sizes and the
// coefficient loader state encoding.
package fir_pkg;

   localparam int DEF_DATA_WIDTH = 24;
   localparam int DEF_FIR_DEPTH  = 128;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD      = 2'd1,
      ST_WAIT_SWAP = 2'd2
   } loader_state_t;

endpackage

// File: rtl/coef_bank.sv
// Double-buffered coefficient storage: a shadow bank written one tap at a time
// and an active bank that copies the whole shadow bank in one edge on commit.
module coef_bank #(
   parameter int DATA_WIDTH = 24,
   parameter int FIR_DEPTH  = 128,
   localparam int IDX_WIDTH = $clog2(FIR_DEPTH)
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_we,
   input  logic [IDX_WIDTH-1:0]            iv_addr,
   input  logic [DATA_WIDTH-1:0]           iv_data,
   input  logic                            i_commit,
   output logic [DATA_WIDTH*FIR_DEPTH-1:0] ov_active
);

   genvar gi;
   generate
      for (gi = 0; gi < FIR_DEPTH; gi++) begin : g_tap
         logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
         logic [DATA_WIDTH-1:0] active_q, active_d;

         always_comb begin
            shadow_d = shadow_q;
            active_d = active_q;
            if (i_we && (iv_addr == IDX_WIDTH'(gi))) begin
               shadow_d = iv_data;
            end
            // Commit copies the value held before this edge's write, if any.
            if (i_commit) begin
               active_d = shadow_q;
            end
         end

         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               shadow_q <= '0;
               active_q <= '0;
            end else begin
               shadow_q <= shadow_d;
               active_q <= active_d;
            end
         end

         assign ov_active[gi*DATA_WIDTH +: DATA_WIDTH] = active_q;
      end
   endgenerate

endmodule

// File: rtl/fir_coef_loader.sv
// Streams FIR coefficients into a shadow bank and commits them to the active
// bank on a sample strobe so the filter never sees a mix of old and new weights.
module fir_coef_loader
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int FIR_DEPTH   = DEF_FIR_DEPTH,
   localparam int ADDR_WIDTH = $clog2(FIR_DEPTH) + 1
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_start,
   input  logic [DATA_WIDTH-1:0]           iv_coef,
   input  logic                            i_coef_valid,
   output logic                            o_coef_ready,
   input  logic                            i_sample_en,
   output logic [DATA_WIDTH*FIR_DEPTH-1:0] ov_weights,
   output logic [ADDR_WIDTH-1:0]           ov_count,
   output logic                            o_busy,
   output logic                            o_done,
   output logic                            o_error
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FIR_DEPTH - 1);

   loader_state_t         state_q, state_d;
   logic [ADDR_WIDTH-1:0] count_q, count_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  bank_we;
   logic                  bank_commit;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      done_d      = 1'b0;
      error_d     = 1'b0;
      bank_we     = 1'b0;
      bank_commit = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d = ST_LOAD;
               count_d = '0;
            end
         end
         ST_LOAD: begin
            // A restart drops any coefficient offered on the same edge.
            if (i_start) begin
               error_d = 1'b1;
               count_d = '0;
            end else if (i_coef_valid) begin
               bank_we = 1'b1;
               count_d = count_q + ADDR_WIDTH'(1);
               if (count_q == LAST_IDX) begin
                  state_d = ST_WAIT_SWAP;
               end
            end
         end
         ST_WAIT_SWAP: begin
            if (i_start) begin
               error_d = 1'b1;
               state_d = ST_LOAD;
               count_d = '0;
            end else if (i_sample_en) begin
               bank_commit = 1'b1;
               done_d      = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   coef_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .FIR_DEPTH (FIR_DEPTH)
   ) u_bank (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_we     (bank_we),
      .iv_addr  (count_q[ADDR_WIDTH-2:0]),
      .iv_data  (iv_coef),
      .i_commit (bank_commit),
      .ov_active(ov_weights)
   );

   assign o_coef_ready = (state_q == ST_LOAD);
   assign o_busy       = (state_q != ST_IDLE);
   assign ov_count     = count_q;
   assign o_done       = done_q;
   assign o_error      = error_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader with a 4-tap, 24-bit configuration.
module tb_fir_coef_loader;

   localparam int DW = 24;
   localparam int NT = 4;
   localparam int AW = $clog2(NT) + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [DW-1:0]     coef = '0;
   logic              coef_valid = 1'b0;
   logic              coef_ready;
   logic              sample_en = 1'b0;
   logic [DW*NT-1:0]  weights;
   logic [AW-1:0]     count;
   logic              busy;
   logic              done;
   logic              error;

   int total = 0;
   int bad   = 0;

   localparam logic [95:0] W_T2 = 96'h000004_000003_000002_000001;
   localparam logic [95:0] W_T4 = 96'h000013_000012_000011_000010;
   localparam logic [95:0] W_T5 = 96'h000000_FFFFFF_7FFFFF_800000;
   localparam logic [95:0] W_T6 = 96'h555555_AAAAAA_123456_654321;

   typedef struct {
      logic          start;
      logic          valid;
      logic [23:0]   coef;
      logic          sample;
      logic [2:0]    exp_count;
      logic          exp_ready;
      logic          exp_busy;
      logic          exp_done;
      logic          exp_error;
      logic [95:0]   exp_weights;
   } vec_t;

   vec_t tbl[9];

   fir_coef_loader #(
      .DATA_WIDTH(DW),
      .FIR_DEPTH (NT)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .iv_coef     (coef),
      .i_coef_valid(coef_valid),
      .o_coef_ready(coef_ready),
      .i_sample_en (sample_en),
      .ov_weights  (weights),
      .ov_count    (count),
      .o_busy      (busy),
      .o_done      (done),
      .o_error     (error)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_status(input string tag, input logic [2:0] c, input logic r,
                               input logic b, input logic d, input logic e,
                               input logic [95:0] w);
      check({tag, " count"},   96'(count),      96'(c));
      check({tag, " ready"},   96'(coef_ready), 96'(r));
      check({tag, " busy"},    96'(busy),       96'(b));
      check({tag, " done"},    96'(done),       96'(d));
      check({tag, " error"},   96'(error),      96'(e));
      check({tag, " weights"}, weights,         w);
   endtask

   task automatic load4(input logic [95:0] v);
      for (int i = 0; i < NT; i++) begin
         coef       = v[i*24 +: 24];
         coef_valid = 1'b1;
         step();
      end
      coef_valid = 1'b0;
   endtask

   function automatic vec_t mk(input logic st, input logic va, input logic [23:0] cf,
                               input logic se, input logic [2:0] c, input logic r,
                               input logic b, input logic d, input logic e,
                               input logic [95:0] w);
      vec_t t;
      t.start = st; t.valid = va; t.coef = cf; t.sample = se;
      t.exp_count = c; t.exp_ready = r; t.exp_busy = b;
      t.exp_done = d; t.exp_error = e; t.exp_weights = w;
      return t;
   endfunction

   initial begin
      // Straight load: start, four coefficients with valid held, strobe 3 cycles later.
      tbl[0] = mk(1, 0, 24'h0,      0, 3'd0, 1, 1, 0, 0, 96'h0);
      tbl[1] = mk(0, 1, 24'h000001, 0, 3'd1, 1, 1, 0, 0, 96'h0);
      tbl[2] = mk(0, 1, 24'h000002, 0, 3'd2, 1, 1, 0, 0, 96'h0);
      tbl[3] = mk(0, 1, 24'h000003, 0, 3'd3, 1, 1, 0, 0, 96'h0);
      tbl[4] = mk(0, 1, 24'h000004, 0, 3'd4, 0, 1, 0, 0, 96'h0);
      tbl[5] = mk(0, 0, 24'h0,      0, 3'd4, 0, 1, 0, 0, 96'h0);
      tbl[6] = mk(0, 0, 24'h0,      0, 3'd4, 0, 1, 0, 0, 96'h0);
      tbl[7] = mk(0, 0, 24'h0,      1, 3'd4, 0, 0, 1, 0, W_T2);
      tbl[8] = mk(0, 0, 24'h0,      0, 3'd4, 0, 0, 0, 0, W_T2);

      // Reset state
      step();
      step();
      check_status("reset", 3'd0, 0, 0, 0, 0, 96'h0);
      rst = 1'b0;
      step();
      check_status("post-reset", 3'd0, 0, 0, 0, 0, 96'h0);

      // Test 2: table
      for (int i = 0; i < 9; i++) begin
         start      = tbl[i].start;
         coef_valid = tbl[i].valid;
         coef       = tbl[i].coef;
         sample_en  = tbl[i].sample;
         step();
         $display("vec %0d: start=%0d valid=%0d coef=%06h sample=%0d -> count=%0d ready=%0d busy=%0d done=%0d err=%0d",
                  i, tbl[i].start, tbl[i].valid, tbl[i].coef, tbl[i].sample,
                  count, coef_ready, busy, done, error);
         check_status($sformatf("t2 vec%0d", i), tbl[i].exp_count, tbl[i].exp_ready,
                      tbl[i].exp_busy, tbl[i].exp_done, tbl[i].exp_error, tbl[i].exp_weights);
      end
      start = 1'b0; coef_valid = 1'b0; sample_en = 1'b0;

      // Test 4: restart mid-load, with a coefficient offered on the restart edge
      start = 1'b1; step(); start = 1'b0;
      coef = 24'h0000AA; coef_valid = 1'b1; step();
      coef = 24'h0000BB; step();
      check("t4 count2", 96'(count), 96'd2);
      start = 1'b1; coef = 24'h0000CC; step();
      start = 1'b0; coef_valid = 1'b0;
      $display("t4 restart: count=%0d err=%0d", count, error);
      check_status("t4 restart", 3'd0, 1, 1, 0, 1, W_T2);
      step();
      check("t4 error pulse end", 96'(error), 96'd0);
      load4(W_T4);
      check_status("t4 loaded", 3'd4, 0, 1, 0, 0, W_T2);
      sample_en = 1'b1; step(); sample_en = 1'b0;
      $display("t4 commit: weights=%024h done=%0d", weights, done);
      check_status("t4 commit", 3'd4, 0, 0, 1, 0, W_T4);

      // Test 3: valid on alternate cycles, then valid pushed while ready is low
      start = 1'b1; step(); start = 1'b0;
      begin
         int hs = 0;
         for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc % 2 == 0) begin
               coef_valid = 1'b1;
               coef       = 24'(hs + 1);
            end else begin
               coef_valid = 1'b0;
            end
            step();
            if (cyc % 2 == 0) hs++;
            $display("t3 cyc %0d: valid=%0d count=%0d ready=%0d", cyc, coef_valid, count, coef_ready);
            check($sformatf("t3 count c%0d", cyc), 96'(count), 96'(hs));
            check($sformatf("t3 ready c%0d", cyc), 96'(coef_ready), 96'(hs < NT));
         end
      end
      coef = 24'hBAD000; coef_valid = 1'b1; step();
      check_status("t3 backpressure", 3'd4, 0, 1, 0, 0, W_T4);
      coef_valid = 1'b0; sample_en = 1'b1; step(); sample_en = 1'b0;
      $display("t3 commit: weights=%024h", weights);
      check_status("t3 commit", 3'd4, 0, 0, 1, 0, W_T2);

      // Test 5: strobe on the final-handshake edge must not commit
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < NT; i++) begin
         coef       = W_T5[i*24 +: 24];
         coef_valid = 1'b1;
         sample_en  = (i == NT - 1);
         step();
      end
      coef_valid = 1'b0; sample_en = 1'b0;
      check_status("t5 final hs", 3'd4, 0, 1, 0, 0, W_T2);
      step();
      check_status("t5 wait", 3'd4, 0, 1, 0, 0, W_T2);
      sample_en = 1'b1; step(); sample_en = 1'b0;
      $display("t5 commit: weights=%024h done=%0d", weights, done);
      check_status("t5 commit", 3'd4, 0, 0, 1, 0, W_T5);
      step();
      check("t5 done once", 96'(done), 96'd0);

      // Test 6: restart coincident with a commit strobe
      start = 1'b1; step(); start = 1'b0;
      load4(W_T6);
      check("t6 busy", 96'(busy), 96'd1);
      start = 1'b1; sample_en = 1'b1; step();
      start = 1'b0; sample_en = 1'b0;
      $display("t6 restart+strobe: count=%0d err=%0d done=%0d", count, error, done);
      check_status("t6 restart", 3'd0, 1, 1, 0, 1, W_T5);
      step();
      check_status("t6 hold", 3'd0, 1, 1, 0, 0, W_T5);

      // Test 1: asynchronous reset between edges, mid-load
      coef = 24'h123456; coef_valid = 1'b1; step(); coef_valid = 1'b0;
      check("t1 count before", 96'(count), 96'd1);
      #3 rst = 1'b1;
      #1;
      $display("t1 async reset: weights=%024h ready=%0d busy=%0d", weights, coef_ready, busy);
      check_status("t1 async", 3'd0, 0, 0, 0, 0, 96'h0);
      step();
      rst = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      check_status("t1 restart", 3'd0, 1, 1, 0, 0, 96'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
